// File: rtl/ospfb_frame_sequencer.sv
// OSPFB frame sequencer: beat/frame counting, oversampled circular-shift offset and FFT config loading.
// Optional FFT overflow monitor is built when OSPFB_SEQ_OVF_MON_EN is defined.
module ospfb_frame_sequencer #(
  parameter int FFT_LEN      = 2048,
  parameter int DEC_FAC      = 1536,
  parameter int SAMP_PER_CLK = 16,
  parameter int FFT_CONF_WID = 16,
  parameter int FFT_STAT_WID = 8,
  parameter int FFT_USER_WID = 8,
  parameter logic [FFT_CONF_WID-1:0] CFG_DEFAULT = 16'h0000,
  localparam int MB = FFT_LEN / SAMP_PER_CLK,
  localparam int DB = DEC_FAC / SAMP_PER_CLK,
  localparam int OW = $clog2(MB)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [FFT_CONF_WID-1:0] cfg_word,
  input  logic                    cfg_wr,
  output logic [FFT_CONF_WID-1:0] m_axis_config_tdata,
  output logic                    m_axis_config_tvalid,
  input  logic                    m_axis_config_tready,
  output logic                    sb_valid,
  output logic                    sb_first,
  output logic                    sb_last,
  output logic [OW-1:0]           sb_offset,
  output logic [FFT_USER_WID-1:0] sb_frame,
  input  logic                    stat_tvalid,
  input  logic [FFT_STAT_WID-1:0] stat_tdata,
  input  logic                    ovf_clr,
  output logic                    ovf_sticky,
  output logic [15:0]             ovf_cnt,
  output logic                    dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high; valid never
  // waits on ready, and the config word is held stable while tvalid is high and tready is low.
  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  localparam int OW1 = OW + 1;
  localparam logic [OW-1:0] LAST_BEAT = OW'(MB - 1);
  localparam logic [OW:0]   MB_EXT    = OW1'(MB);
  localparam logic [OW:0]   DB_EXT    = OW1'(DB);

  state_t                  state, state_nxt;
  logic [OW-1:0]           beat_cnt;
  logic [OW-1:0]           offset;
  logic [OW-1:0]           offset_nxt;
  logic [OW:0]             offset_add;
  logic [FFT_USER_WID-1:0] frame_cnt;
  logic                    pend;
  logic [FFT_CONF_WID-1:0] pend_word;
  logic [FFT_CONF_WID-1:0] active_word;
  logic                    accept;
  logic                    frame_wrap;
  logic                    cfg_take;
  logic                    cfg_hs;

  // Ready depends on registered state only; a pending config blocks the first beat of a frame.
  assign s_ready              = (state == S_RUN) && !(pend && (beat_cnt == '0));
  assign m_axis_config_tvalid = (state == S_LOAD) && !rst;
  assign m_axis_config_tdata  = active_word;
  assign dbg_state            = state;

  always_comb begin
    accept     = s_valid && s_ready;
    frame_wrap = accept && (beat_cnt == LAST_BEAT);
    cfg_take   = (state == S_RUN) && pend && (beat_cnt == '0);
    cfg_hs     = m_axis_config_tvalid && m_axis_config_tready;
    offset_add = {1'b0, offset} + DB_EXT;
    offset_nxt = OW'((offset_add >= MB_EXT) ? (offset_add - MB_EXT) : offset_add);
    state_nxt  = state;
    case (state)
      S_LOAD: if (cfg_hs) state_nxt = S_RUN;
      S_RUN:  if (cfg_take) state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      beat_cnt    <= '0;
      offset      <= '0;
      frame_cnt   <= '0;
      pend        <= 1'b0;
      pend_word   <= CFG_DEFAULT;
      active_word <= CFG_DEFAULT;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (frame_wrap) begin
          beat_cnt  <= '0;
          offset    <= offset_nxt;
          frame_cnt <= frame_cnt + FFT_USER_WID'(1);
        end else begin
          beat_cnt <= beat_cnt + OW'(1);
        end
      end
      // A write on the take cycle stays pending for the following boundary.
      if (cfg_wr) begin
        pend      <= 1'b1;
        pend_word <= cfg_word;
      end else if (cfg_take) begin
        pend <= 1'b0;
      end
      if (cfg_take) active_word <= pend_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid  <= 1'b0;
      sb_first  <= 1'b0;
      sb_last   <= 1'b0;
      sb_offset <= '0;
      sb_frame  <= '0;
    end else begin
      sb_valid <= accept;
      sb_first <= accept && (beat_cnt == '0);
      sb_last  <= frame_wrap;
      if (accept) begin
        sb_offset <= offset;
        sb_frame  <= frame_cnt;
      end
    end
  end

`ifdef OSPFB_SEQ_OVF_MON_EN
  logic unused_stat;
  assign unused_stat = ^stat_tdata[FFT_STAT_WID-1:1];

  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (stat_tvalid && stat_tdata[0]) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_tvalid, stat_tdata, ovf_clr};
  assign ovf_sticky  = 1'b0;
  assign ovf_cnt     = '0;
`endif

endmodule

// File: doc/ospfb_frame_sequencer.md
# ospfb_frame_sequencer

Frame-level controller for the oversampled polyphase filterbank (OSPFB) datapath. It counts accepted sample beats into FFT frames of FFT_LEN/SAMP_PER_CLK beats and generates the circular-shift offset that compensates the oversampled phase rotation ((frame·DEC_FAC) mod FFT_LEN). It also owns the FFT core's AXI-Stream config channel, loading the configuration word after reset and on request, only at frame boundaries. It sits between the PFB filter output and the FFT core and drives the shift stage and FFT sideband signals.

## Interface
- FFT_LEN, 2048, polyphase branches (M); must be divisible by SAMP_PER_CLK.
- DEC_FAC, 1536, decimation factor (D); must be divisible by SAMP_PER_CLK.
- SAMP_PER_CLK, 16, samples per beat.
- FFT_CONF_WID, 16, FFT config word width.
- FFT_STAT_WID, 8, FFT status width; bit 0 is overflow.
- FFT_USER_WID, 8, frame-counter sideband width.
- CFG_DEFAULT, 16'h0000, config word loaded after reset.
- Derived: MB = FFT_LEN/SAMP_PER_CLK (128), DB = DEC_FAC/SAMP_PER_CLK (96), OW = $clog2(MB) (7).
- clk  in  1  DSP clock. One clock domain only.
- rst  in  1  Synchronous, active-high reset.
- s_valid  in  1  Upstream beat valid.
- s_ready  out  1  Beat accepted when s_valid && s_ready.
- cfg_word  in  FFT_CONF_WID  New FFT config (inverse bit plus scale schedule).
- cfg_wr  in  1  Single-cycle strobe that latches cfg_word as pending.
- m_axis_config_tdata  out  FFT_CONF_WID  Config word to the FFT core.
- m_axis_config_tvalid  out  1  Config valid.
- m_axis_config_tready  in  1  Config ready from the FFT core.
- sb_valid  out  1  Registered copy of beat accept.
- sb_first  out  1  Beat 0 of a frame.
- sb_last  out  1  Beat MB-1 of a frame (FFT tlast).
- sb_offset  out  OW  Circular-shift offset for the current frame, in beats.
- sb_frame  out  FFT_USER_WID  Frame counter (FFT tuser); wraps.
- stat_tvalid  in  1  FFT status valid.
- stat_tdata  in  FFT_STAT_WID  FFT status word.
- ovf_clr  in  1  Clears the overflow monitor.
- ovf_sticky  out  1  Sticky FFT overflow flag.
- ovf_cnt  out  16  Saturating count of overflow frames.

## Operation
- States:
  - LOAD: drive tvalid=1 with tdata = active word; s_ready=0. Go to RUN on tvalid && tready.
  - RUN: accept beats.
  - Reset enters LOAD with active word = CFG_DEFAULT.
- s_ready = (state==RUN) && !(pend && beat_cnt==0).
- Pending config:
  - cfg_wr sets pend and latches cfg_word into pend_word.
  - When pend is set and beat_cnt==0 in RUN, move pend_word to the active word, clear pend, and go to LOAD.
  - Frames are never split by a config load.
- cfg_wr while pend is set: the newer word overwrites (last-write-wins).
- cfg_wr in the same cycle as a LOAD handshake: the new word becomes pending and loads at the next boundary.
- Beat counter beat_cnt (0..MB-1):
  - Increments on accept and wraps MB-1 → 0.
  - On that wrap, frame_cnt increments and offset ← (offset + DB) mod MB.
  - Offset sequence for the defaults: 0, 96, 64, 32, 0, …
- The offset add uses OW+1 bits with a conditional subtract of MB; no divider.
- rst mid-frame: beat_cnt, offset, frame_cnt and pend are cleared; the next accepted beat is the first beat of a new frame.

## Timing
- Sideband latency is 1 cycle. The sb_* outputs reflect the beat accepted in the previous cycle, with that beat's first/last/offset/frame values.
- s_ready is combinational from registered state only; there is no path from s_valid to s_ready.
- Config latency: the first LOAD tvalid is asserted in the cycle after rst deasserts.
- After a handshake at cycle t, s_ready may rise at t+1.
- tdata is stable while tvalid=1 and tready=0.
- Reset values:
  - s_ready=0, m_axis_config_tvalid=0, m_axis_config_tdata=CFG_DEFAULT.
  - All sb_*=0.
  - ovf_sticky=0, ovf_cnt=0.

## Configuration
- OSPFB_SEQ_OVF_MON_EN defined:
  - On stat_tvalid && stat_tdata[0], set ovf_sticky and increment ovf_cnt, saturating at 16'hFFFF.
  - ovf_clr has priority over a simultaneous event and clears both.
- Not defined: ovf_sticky and ovf_cnt are tied to 0; stat_* and ovf_clr are ignored. All ports remain present.

## Test plan
- Reset, tready=1 → tvalid is high for exactly 1 cycle with tdata=16'h0000; s_ready rises the next cycle.
- s_valid held high for 512 beats → sb_first on beats 0/128/256/384, sb_last on beats 127/255/383/511, sb_offset 0/96/64/32, sb_frame 0..3.
- cfg_wr with 16'h0A5B at beat 40 of a frame → beats 41..127 still accepted; then s_ready=0, tdata=16'h0A5B until tready; sb_offset continues at the next value.
- Two cfg_wr in one frame (16'h0001, then 16'h0002) → only one load, with 16'h0002.
- rst asserted at beat 70 of frame 2 → all outputs return to reset values; the next frame starts at offset 0, sb_frame=0.
- With OSPFB_SEQ_OVF_MON_EN: three status beats with bit0=1 → ovf_cnt=3, ovf_sticky=1; ovf_clr coincident with a fourth event → both 0.
